// File: rtl/button_irq_servicer.sv
// Autonomous servicer for the 4-bit button PIO: programs irq_mask, then drains edge_capture into an event FIFO.
// Optional BTN_SVC_TIMESTAMP_EN stores a 16-bit free-running timestamp with every event (evt_ts output).
module button_irq_servicer #(
    parameter logic [3:0] MASK   = 4'hF,
    parameter int         DEPTH  = 4,
    parameter int         RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pio_irq,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        evt_valid,
    output logic [3:0]  evt_data,
    input  logic        evt_ready,
    output logic        ovf,
    input  logic        ovf_clr,
`ifdef BTN_SVC_TIMESTAMP_EN
    output logic [15:0] evt_ts,
`endif
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);
`ifdef BTN_SVC_TIMESTAMP_EN
    localparam int EW = 20;
`else
    localparam int EW = 4;
`endif

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CAP, S_PUSH, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [3:0]    cap_q;
    logic          cs, wr_n;
    logic [1:0]    addr;
    logic [31:0]   wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        cs       = 1'b0;
        wr_n     = 1'b1;
        addr     = 2'd0;
        wdata    = 32'd0;
        case (state_q)
            S_INIT: begin
                cs      = 1'b1;
                wr_n    = 1'b0;
                addr    = 2'd2;
                wdata   = {28'd0, MASK};
                state_d = S_IDLE;
            end
            S_IDLE: if (pio_irq) state_d = S_RD;
            S_RD: begin
                cs   = 1'b1;
                addr = 2'd3;
                if (rd_cnt_q == CW'(RD_LAT - 1)) begin
                    rd_cnt_d = '0;
                    state_d  = S_CAP;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            // readdata is sampled and edge_capture cleared in the same cycle
            S_CAP: begin
                cs      = 1'b1;
                wr_n    = 1'b0;
                addr    = 2'd3;
                state_d = S_PUSH;
            end
            S_PUSH:  state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // State resets to INIT, so gate the bus with reset_n to keep it idle while reset is held.
    assign avm_chipselect = cs & reset_n;
    assign avm_write_n    = wr_n | ~reset_n;
    assign avm_address    = reset_n ? addr : 2'd0;
    assign avm_writedata  = reset_n ? wdata : 32'd0;
    assign busy           = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              cap_q <= '0;
        else if (state_q == S_CAP) cap_q <= avm_readdata[3:0];
    end

    logic [EW-1:0] entry;
`ifdef BTN_SVC_TIMESTAMP_EN
    logic [15:0] ts_q, cap_ts_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q     <= '0;
            cap_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            if (state_q == S_CAP) cap_ts_q <= ts_q;
        end
    end
    assign entry = {cap_ts_q, cap_q};
`else
    assign entry = cap_q;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, pop, push_req, push_ok, drop;
    logic [EW-1:0] head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = evt_valid & evt_ready;
    assign push_req = (state_q == S_PUSH) && (cap_q != 4'd0);
    // a same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            if (ovf_clr)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid = ~empty;
    assign evt_data  = empty ? 4'd0 : head[3:0];
`ifdef BTN_SVC_TIMESTAMP_EN
    assign evt_ts    = empty ? 16'd0 : head[19:4];
`endif

endmodule

// File: tb/tb_button_irq_servicer.sv
// Directed bench for button_irq_servicer with a small behavioural model of the button PIO.
module tb_button_irq_servicer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pio_irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        evt_valid;
    logic [3:0]  evt_data;
    logic        evt_ready = 1'b0;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic        busy;
`ifdef BTN_SVC_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    int errors = 0;
    int checks = 0;

    // PIO model
    logic [3:0]  ecap;
    logic [3:0]  inj = 4'd0;
    logic        irq_force = 1'b0;
    logic [31:0] mask_model;
    int          clr_cnt, init_cnt;

    assign pio_irq = (|(ecap & mask_model[3:0])) | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecap         <= 4'd0;
            avm_readdata <= 32'd0;
            mask_model   <= 32'd0;
            clr_cnt      <= 0;
            init_cnt     <= 0;
        end else begin
            avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 2'd3) ? {28'd0, ecap} : 32'd0;
            if (inj != 4'd0) ecap <= ecap | inj;
            else if (avm_chipselect && !avm_write_n && avm_address == 2'd3) ecap <= 4'd0;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) clr_cnt <= clr_cnt + 1;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) begin
                mask_model <= avm_writedata;
                init_cnt   <= init_cnt + 1;
            end
        end
    end

    always #5 clk = ~clk;

    button_irq_servicer #(.MASK(4'hF), .DEPTH(4), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .pio_irq(pio_irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .ovf(ovf), .ovf_clr(ovf_clr),
`ifdef BTN_SVC_TIMESTAMP_EN
        .evt_ts(evt_ts),
`endif
        .busy(busy)
    );

    // inject an edge, then wait for the FSM to walk RD..HOLD and return to IDLE
    task automatic event_in(input logic [3:0] v);
        @(negedge clk); inj = v;
        @(negedge clk); inj = 4'd0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop_expect(input string name, input logic [3:0] exp);
        @(negedge clk);
        checks++;
        if ({evt_valid, evt_data} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL %s got valid=%0b data=%h exp valid=1 data=%h", name, evt_valid, evt_data, exp);
        end
        evt_ready = 1'b1;
        @(negedge clk); evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd0, 1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL rst_bus got a=%0d cs=%0b wn=%0b wd=%h", avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        checks++;
        if ({evt_valid, evt_data, ovf, busy} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_out got v=%0b d=%h ovf=%0b busy=%0b exp 0,0,0,1", evt_valid, evt_data, ovf, busy);
        end
        @(negedge clk); reset_n = 1'b1; #1;
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd2, 1'b1, 1'b0, 32'h0000000F}) begin
            errors++;
            $display("FAIL init_wr got a=%0d cs=%0b wn=%0b wd=%h exp 2,1,0,0000000f", avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        @(negedge clk);
        checks++;
        if ({busy, avm_chipselect, mask_model} !== {1'b0, 1'b0, 32'h0000000F}) begin
            errors++;
            $display("FAIL idle got busy=%0b cs=%0b mask=%h exp 0,0,0000000f", busy, avm_chipselect, mask_model);
        end
    endtask

    task automatic test_single;
        int c0;
        c0 = clr_cnt;
        @(negedge clk); inj = 4'b0100;
        @(negedge clk); inj = 4'd0;           // IDLE, irq high
        @(negedge clk);                        // RD
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, busy} !== {2'd3, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rd_bus got a=%0d cs=%0b wn=%0b busy=%0b exp 3,1,1,1", avm_address, avm_chipselect, avm_write_n, busy);
        end
        @(negedge clk);                        // CAP
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd3, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL clr_bus got a=%0d cs=%0b wn=%0b wd=%h exp 3,1,0,0", avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        @(negedge clk);                        // PUSH
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early got valid=%0b exp 0", evt_valid);
        end
        @(negedge clk);                        // HOLD, push visible
        checks++;
        if ({evt_valid, evt_data, ecap, clr_cnt - c0} !== {1'b1, 4'h4, 4'd0, 32'd1}) begin
            errors++;
            $display("FAIL lat_5 got valid=%0b data=%h ecap=%h clr=%0d exp 1,4,0,1", evt_valid, evt_data, ecap, clr_cnt - c0);
        end
        @(negedge clk);
        pop_expect("single_pop", 4'h4);
        checks++;
        if ({evt_valid, evt_data, busy} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_empty got valid=%0b data=%h busy=%0b exp 0,0,0", evt_valid, evt_data, busy);
        end
    endtask

    task automatic test_overflow;
        event_in(4'h1); event_in(4'h2); event_in(4'h4); event_in(4'h8);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got ovf=%0b exp 0", ovf);
        end
        event_in(4'hF);
        checks++;
        if ({ovf, evt_valid, evt_data} !== {1'b1, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL ovf_set got ovf=%0b valid=%0b data=%h exp 1,1,1", ovf, evt_valid, evt_data);
        end
        pop_expect("ovf_pop0", 4'h1);
        pop_expect("ovf_pop1", 4'h2);
        pop_expect("ovf_pop2", 4'h4);
        pop_expect("ovf_pop3", 4'h8);
        checks++;
        if ({evt_valid, ovf} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_drained got valid=%0b ovf=%0b exp 0,1", evt_valid, ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got ovf=%0b exp 0", ovf);
        end
    endtask

    task automatic test_full_pop;
        event_in(4'h1); event_in(4'h2); event_in(4'h4); event_in(4'h8);
        @(negedge clk); inj = 4'h3;
        @(negedge clk); inj = 4'd0;
        @(negedge clk);                        // RD
        @(negedge clk);                        // CAP
        @(negedge clk); evt_ready = 1'b1;      // PUSH while full, pop same cycle
        @(negedge clk); evt_ready = 1'b0;
        checks++;
        if ({ovf, evt_valid, evt_data} !== {1'b0, 1'b1, 4'h2}) begin
            errors++;
            $display("FAIL fullpop got ovf=%0b valid=%0b data=%h exp 0,1,2", ovf, evt_valid, evt_data);
        end
        @(negedge clk);
        pop_expect("fp_pop0", 4'h2);
        pop_expect("fp_pop1", 4'h4);
        pop_expect("fp_pop2", 4'h8);
        pop_expect("fp_tail", 4'h3);
        checks++;
        if ({evt_valid, ovf} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fp_empty got valid=%0b ovf=%0b exp 0,0", evt_valid, ovf);
        end
    endtask

    task automatic test_spurious;
        int c0;
        c0 = clr_cnt;
        @(negedge clk); irq_force = 1'b1;
        @(negedge clk); irq_force = 1'b0;      // RD already entered
        repeat (5) @(negedge clk);
        checks++;
        if ({evt_valid, busy, clr_cnt - c0} !== {1'b0, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL spurious got valid=%0b busy=%0b clr=%0d exp 0,0,1", evt_valid, busy, clr_cnt - c0);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); inj = 4'h1;
        @(negedge clk); inj = 4'd0;
        @(negedge clk);                        // RD
        checks++;
        if ({avm_chipselect, avm_address} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL mid_rd got cs=%0b a=%0d exp 1,3", avm_chipselect, avm_address);
        end
        #2 reset_n = 1'b0; #1;
        checks++;
        if ({avm_chipselect, avm_write_n, busy} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_abort got cs=%0b wn=%0b busy=%0b exp 0,1,1", avm_chipselect, avm_write_n, busy);
        end
        @(negedge clk); reset_n = 1'b1; #1;
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd2, 1'b1, 1'b0, 32'h0000000F}) begin
            errors++;
            $display("FAIL mid_reinit got a=%0d cs=%0b wn=%0b wd=%h", avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        @(negedge clk);
        checks++;
        if ({init_cnt, busy, evt_valid} !== {32'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_idle got init=%0d busy=%0b valid=%0b exp 1,0,0", init_cnt, busy, evt_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_overflow;
        test_full_pop;
        test_spurious;
        test_reset_mid;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/button_irq_servicer.md
Name: button_irq_servicer

Overview:
- Hardware servicer for the 4-bit button PIO, which provides edge capture, an IRQ mask and an IRQ output.
- After reset it configures the PIO IRQ mask over the PIO's Avalon-MM slave port.
- On each IRQ it reads edge_capture, clears it, and pushes the captured button bits into a small event FIFO.
- The FIFO is consumed by the recognition control logic, so button handling needs no Nios II ISR.
- Sits between the PIO slave and fabric consumers; the CPU may still read the PIO through the interconnect.

Parameters:
- MASK, 4'hF, irq_mask value written to PIO address 2 after reset.
- DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- RD_LAT, 1, PIO readdata latency in cycles after the read address is presented.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- pio_irq  in  1  PIO interrupt (OR of edge_capture & irq_mask)
- avm_address  out  2  PIO register address
- avm_chipselect  out  1  PIO select
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  PIO write data
- avm_readdata  in  32  PIO registered readdata
- evt_valid  out  1  FIFO non-empty
- evt_data  out  4  head event, one bit per button
- evt_ready  in  1  consumer pop; pop occurs when evt_valid & evt_ready
- ovf  out  1  sticky overflow, an event was dropped
- ovf_clr  in  1  clears ovf
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (reset_n async, active-low; clock clk):
  - avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
  - FIFO empty, evt_valid=0, evt_data=0, ovf=0, busy=1.
  - FSM enters INIT.
- FSM states:
  - INIT: 1 cycle. Drive chipselect=1, write_n=0, address=2, writedata={28'b0,MASK}. Go to IDLE.
  - IDLE: bus idle (chipselect=0, write_n=1). If pio_irq=1, go to RD.
  - RD: drive address=3, chipselect=1, write_n=1. Hold address=3 for RD_LAT cycles, then go to CAP.
  - CAP: 1 cycle.
    - Latch cap=avm_readdata[3:0].
    - In the same cycle drive chipselect=1, write_n=0, address=3, writedata=0 to clear edge_capture.
    - Go to PUSH.
  - PUSH: 1 cycle.
    - If cap==0: no push (spurious).
    - Else if FIFO not full: write cap.
    - Else: drop cap and set ovf.
    - Go to HOLD.
  - HOLD: 1 cycle, bus idle, lets pio_irq settle after the clear. Go to IDLE.
- Latency: pio_irq rise to evt_valid is 5 cycles with RD_LAT=1 and an empty FIFO (IDLE, RD, CAP, PUSH, write visible next cycle).
- Edges arriving in the cycle between the readdata sample and the clear write are lost. This is an accepted limitation of the PIO clear-all semantics.
- FIFO:
  - First-word-fall-through: evt_data is the head entry whenever evt_valid=1; it is 0 when empty.
  - Pointers wrap modulo DEPTH, with an extra MSB to tell full from empty.
  - Simultaneous push and pop when full: the pop frees the slot, so the push is accepted and no overflow is flagged.
  - Simultaneous push and pop when empty: the push is written and evt_valid goes to 1 the next cycle.
- ovf:
  - Set on a drop.
  - ovf_clr has priority over set in the same cycle.
- Reset mid-operation: reset aborts any bus cycle immediately, and INIT is re-run afterward, rewriting the mask.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: BTN_SVC_TIMESTAMP_EN.
- With the macro defined:
  - A free-running 16-bit counter runs, reset to 0, wrapping at 16'hFFFF.
  - Its value is sampled in CAP and stored alongside cap.
  - An extra output evt_ts[15:0] presents the head entry's timestamp; it is 0 when empty.
- Without the macro: no counter, no evt_ts port, and the FIFO is 4 bits wide.

Test Plan:
- Reset release -> first cycle shows address=2, chipselect=1, write_n=0, writedata=32'h0000000F; then IDLE with busy=0.
- pio_irq=1 with edge_capture model 4'b0100, evt_ready=0 -> address=3 read, clear write to address 3, evt_valid=1 with evt_data=4'h4 5 cycles after the irq rise.
- Four irqs returning 1,2,4,8 with DEPTH=4, then one more returning 4'hF, evt_ready=0 -> FIFO full, ovf=1, entries are still 1,2,4,8. Pop all -> evt_valid=0. Pulse ovf_clr -> ovf=0.
- FIFO full, evt_ready=1 in the same cycle as PUSH of 4'h3 -> no ovf; 4'h3 ends up at the tail.
- irq asserted but readdata 0 -> clear write still issued, no FIFO push.
- reset_n pulsed low during RD -> chipselect=0 asynchronously; after release the INIT mask write is repeated.
